ahb_bus_arbiter: RTL and testbench
==================================

# ahb_bus_arbiter

Two-master, one-slave AHB-Lite arbiter that shares the single system bus between the instruction-fetch port (IF) and the load/store port (LS). It sits between the IF/LS AHB interface blocks and the bus fabric. It serialises their requests into non-pipelined AHB transfers and returns read data and errors to the winning master. Its busy/grant status feeds the pipeline controller's IF and LS stall requests.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_req_i  in  1  IF read request; held until if_gnt_o
- if_addr_i  in  ADDR_W  IF fetch address (word, HSIZE=2)
- if_flush_i  in  1  IF flush from pipeline control; drops IF response in flight
- if_gnt_o  out  1  IF address phase accepted (1-cycle pulse)
- if_rvalid_o  out  1  IF response valid (1-cycle pulse)
- if_rdata_o  out  DATA_W  IF read data, valid with if_rvalid_o
- if_err_o  out  1  IF bus error, valid with if_rvalid_o
- ls_req_i, ls_we_i  in  1  LS request, write enable
- ls_addr_i  in  ADDR_W; ls_wdata_i  in  DATA_W; ls_size_i  in  3  LS address, write data, HSIZE
- ls_gnt_o, ls_rvalid_o, ls_err_o  out  1; ls_rdata_o  out  DATA_W  as IF equivalents
- haddr_o  out  ADDR_W; htrans_o  out  2; hwrite_o  out  1; hsize_o  out  3; hwdata_o  out  DATA_W  AHB master outputs
- hrdata_i  in  DATA_W; hready_i  in  1; hresp_i  in  1  AHB slave responses

## Operation
- FSM states IDLE, ADDR, DATA; reset state IDLE.
- IDLE: if any request is pending, pick a winner (see Configuration), latch owner and request fields, go to ADDR.
- ADDR: htrans_o=NONSEQ (2'b10); haddr/hwrite/hsize driven from latched fields; owner gnt_o=1. Move to DATA when hready_i=1, else hold (gnt_o repeats only on the accepting cycle: gnt_o = ADDR & hready_i).
- DATA: htrans_o=IDLE; hwdata_o = latched wdata. When hready_i=1: register hrdata_i/hresp_i into owner rdata/err and set owner rvalid next cycle. Then go to ADDR if a request is pending (new arbitration), else IDLE.
- IF reads always: hwrite_o=0, hsize_o=3'b010.
- Flush: if_flush_i while owner=IF in DATA, or coincident with IF completion, sets a drop flag; the IF response is suppressed (if_rvalid_o stays 0). The bus transfer still completes. A flush in IDLE/ADDR has no effect; the IF master withdraws its own request.
- hresp_i=1 in DATA: transfer ends on the hready_i=1 cycle; err_o=1 with rvalid; rdata undefined (driven 0).
- The arbiter never cancels a transfer once it is in ADDR.
- Reset values: all gnt/rvalid/err 0; rdata 0; haddr_o 0; htrans_o 2'b00; hwrite_o 0; hsize_o 3'b010; hwdata_o 0; owner=LS; rr pointer=IF.

## Timing
- Minimum request-to-rvalid latency is 3 cycles: req seen at edge 0, ADDR in cycle 1 (gnt), DATA in cycle 2 (hready_i=1), rvalid in cycle 3.
- Each hready_i=0 cycle in ADDR or DATA adds 1 cycle.
- Back-to-back transfers: DATA→ADDR direct, 2 bus cycles per transfer with zero wait states.
- Masters hold req and all fields stable until gnt. The arbiter latches the fields on the IDLE/DATA→ADDR edge, so changes after that edge are ignored.
- Simultaneous IF and LS requests are resolved on the same edge; the loser waits at least 2 cycles.
- Async reset mid-transfer: immediately returns to IDLE with outputs at reset values; any pending response is lost.

## Configuration
- ARB_ROUND_ROBIN_EN defined: 1-bit round-robin pointer. On contention the grant goes to the master not served last; the pointer updates on each gnt. Neither master waits more than one transfer.
- Undefined: fixed priority, LS over IF. IF is granted only when ls_req_i=0 at the arbitration edge.

## Test plan
- Single IF read, addr 0x0000_0100, hrdata_i 0xDEAD_BEEF, zero wait → if_gnt_o in cycle 1, htrans_o=2'b10/haddr_o=0x100 in cycle 1, if_rvalid_o with 0xDEAD_BEEF in cycle 3.
- LS byte write to 0x2000_0003 with data 0x55 and 2 wait states in DATA → hsize_o=0, hwrite_o=1, hwdata_o=0x55 in DATA, ls_rvalid_o in cycle 5, ls_err_o=0.
- IF and LS request together for 4 transfers each → fixed priority gives all LS transfers first. With ARB_ROUND_ROBIN_EN the grants alternate LS, IF, LS, IF…, 2 cycles apart.
- IF read in DATA with hready_i=0, if_flush_i pulsed → no if_rvalid_o; the next LS request is granted normally after hready_i rises.
- LS read with hresp_i=1 on completion → ls_rvalid_o=1, ls_err_o=1, ls_rdata_o=0.
- rst_n low during a DATA phase → all outputs at reset values asynchronously. After release, a new IF request completes in 3 cycles.

Source files
------------

// File: rtl/ahb_bus_arbiter_if.sv
// Signal bundle between the IF/LS request ports, the ahb_bus_arbiter and the AHB-Lite fabric.
// modport master: the arbiter (it is the AHB bus master); modport slave: the surrounding masters and fabric.
`timescale 1ns/1ps
interface ahb_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch port
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_flush_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_err_o;

  // Load/store port
  logic              ls_req_i;
  logic              ls_we_i;
  logic [ADDR_W-1:0] ls_addr_i;
  logic [DATA_W-1:0] ls_wdata_i;
  logic [2:0]        ls_size_i;
  logic              ls_gnt_o;
  logic              ls_rvalid_o;
  logic [DATA_W-1:0] ls_rdata_o;
  logic              ls_err_o;

  // AHB-Lite bus
  logic [ADDR_W-1:0] haddr_o;
  logic [1:0]        htrans_o;
  logic              hwrite_o;
  logic [2:0]        hsize_o;
  logic [DATA_W-1:0] hwdata_o;
  logic [DATA_W-1:0] hrdata_i;
  logic              hready_i;
  logic              hresp_i;

  modport master (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_size_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
    output haddr_o, htrans_o, hwrite_o, hsize_o, hwdata_o,
    input  hrdata_i, hready_i, hresp_i
  );

  modport slave (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_size_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
    input  haddr_o, htrans_o, hwrite_o, hsize_o, hwdata_o,
    output hrdata_i, hready_i, hresp_i
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Two-master (IF/LS) to one-slave AHB-Lite arbiter issuing non-pipelined transfers.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority LS over IF.
`timescale 1ns/1ps
module ahb_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  ahb_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_DATA = 2'd2} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  state_e            state_q, state_d;
  owner_e            owner_q, winner;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [2:0]        size_q;
  logic [DATA_W-1:0] wdata_q;
  logic              drop_q;

  logic              any_req, accept, done, launch;
  logic              if_done, ls_done;
  logic [DATA_W-1:0] resp_data;

  logic              if_rvalid_q, if_err_q, ls_rvalid_q, ls_err_q;
  logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;

  assign any_req = bus.if_req_i | bus.ls_req_i;
  assign accept  = (state_q == ST_ADDR) & bus.hready_i;
  assign done    = (state_q == ST_DATA) & bus.hready_i;
  // A new owner is chosen from IDLE, or straight out of a completing data phase.
  assign launch  = any_req & ((state_q == ST_IDLE) | done);

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_q;

  always_comb begin
    winner = bus.ls_req_i ? OWN_LS : OWN_IF;
    if (bus.if_req_i && bus.ls_req_i)
      winner = (last_q == OWN_IF) ? OWN_LS : OWN_IF;
  end

  // last_q names the master served most recently; it moves on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_q <= OWN_IF;
    else if (accept) last_q <= owner_q;
  end
`else
  assign winner = bus.ls_req_i ? OWN_LS : OWN_IF;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (any_req)       state_d = ST_ADDR;
      ST_ADDR: if (bus.hready_i)  state_d = ST_DATA;
      ST_DATA: if (bus.hready_i)  state_d = any_req ? ST_ADDR : ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Request fields are captured only at the launch edge; later changes by a master are ignored.
  // NOTE: datapath registers are reset too, because their reset values are visible on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_LS;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= HSIZE_WORD;
      wdata_q <= '0;
    end else if (launch) begin
      owner_q <= winner;
      if (winner == OWN_LS) begin
        addr_q  <= bus.ls_addr_i;
        we_q    <= bus.ls_we_i;
        size_q  <= bus.ls_size_i;
        wdata_q <= bus.ls_wdata_i;
      end else begin
        addr_q  <= bus.if_addr_i;
        we_q    <= 1'b0;
        size_q  <= HSIZE_WORD;
        wdata_q <= '0;
      end
    end
  end

  // A flush during an IF data phase kills its response; the bus transfer itself still finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_q <= 1'b0;
    else if (launch)
      drop_q <= 1'b0;
    else if ((state_q == ST_DATA) && (owner_q == OWN_IF) && bus.if_flush_i)
      drop_q <= 1'b1;
  end

  // The flush term also covers a flush that coincides with the completing cycle.
  assign if_done   = done & (owner_q == OWN_IF) & ~drop_q & ~bus.if_flush_i;
  assign ls_done   = done & (owner_q == OWN_LS);
  assign resp_data = bus.hresp_i ? '0 : bus.hrdata_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= if_done;
      if_err_q    <= if_done & bus.hresp_i;
      ls_rvalid_q <= ls_done;
      ls_err_q    <= ls_done & bus.hresp_i;
      if (if_done) if_rdata_q <= resp_data;
      if (ls_done) ls_rdata_q <= resp_data;
    end
  end

  assign bus.htrans_o    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.haddr_o     = addr_q;
  assign bus.hwrite_o    = we_q;
  assign bus.hsize_o     = size_q;
  assign bus.hwdata_o    = wdata_q;

  assign bus.if_gnt_o    = accept & (owner_q == OWN_IF);
  assign bus.ls_gnt_o    = accept & (owner_q == OWN_LS);
  assign bus.if_rvalid_o = if_rvalid_q;
  assign bus.if_err_o    = if_err_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.ls_rvalid_o = ls_rvalid_q;
  assign bus.ls_err_o    = ls_err_q;
  assign bus.ls_rdata_o  = ls_rdata_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_ahb_bus_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int RND_CYCLES = 3000;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  ahb_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ahb_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Slave read data is a fixed function of the address.
  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  task automatic idle_inputs();
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = '0;
    bus.if_flush_i = 1'b0;
    bus.ls_req_i   = 1'b0;
    bus.ls_we_i    = 1'b0;
    bus.ls_addr_i  = '0;
    bus.ls_wdata_i = '0;
    bus.ls_size_i  = 3'b010;
    bus.hrdata_i   = '0;
    bus.hready_i   = 1'b1;
    bus.hresp_i    = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_htrans"},    bus.htrans_o,    2'b00);
    check({tag, "_haddr"},     bus.haddr_o,     32'h0);
    check({tag, "_hwrite"},    bus.hwrite_o,    1'b0);
    check({tag, "_hsize"},     bus.hsize_o,     3'b010);
    check({tag, "_hwdata"},    bus.hwdata_o,    32'h0);
    check({tag, "_if_gnt"},    bus.if_gnt_o,    1'b0);
    check({tag, "_ls_gnt"},    bus.ls_gnt_o,    1'b0);
    check({tag, "_if_rvalid"}, bus.if_rvalid_o, 1'b0);
    check({tag, "_ls_rvalid"}, bus.ls_rvalid_o, 1'b0);
    check({tag, "_if_err"},    bus.if_err_o,    1'b0);
    check({tag, "_ls_err"},    bus.ls_err_o,    1'b0);
    check({tag, "_if_rdata"},  bus.if_rdata_o,  32'h0);
    check({tag, "_ls_rdata"},  bus.ls_rdata_o,  32'h0);
  endtask

  // Leaves the bench at a falling edge with reset released and the DUT idle.
  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_if();
    idle_inputs();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0100;
    bus.hrdata_i  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("if1_gnt",    bus.if_gnt_o, 1'b1);
    check("if1_ls_gnt", bus.ls_gnt_o, 1'b0);
    check("if1_htrans", bus.htrans_o, 2'b10);
    check("if1_haddr",  bus.haddr_o,  32'h100);
    check("if1_hwrite", bus.hwrite_o, 1'b0);
    check("if1_hsize",  bus.hsize_o,  3'b010);
    bus.if_req_i = 1'b0;
    @(negedge clk);
    check("if1_data_htrans", bus.htrans_o,    2'b00);
    check("if1_rvalid_c2",   bus.if_rvalid_o, 1'b0);
    @(negedge clk);
    check("if1_rvalid_c3", bus.if_rvalid_o, 1'b1);
    check("if1_rdata",     bus.if_rdata_o,  32'hDEAD_BEEF);
    check("if1_err",       bus.if_err_o,    1'b0);
    @(negedge clk);
    check("if1_rvalid_pulse", bus.if_rvalid_o, 1'b0);
  endtask

  task automatic test_ls_write();
    idle_inputs();
    bus.ls_req_i   = 1'b1;
    bus.ls_we_i    = 1'b1;
    bus.ls_addr_i  = 32'h2000_0003;
    bus.ls_wdata_i = 32'h55;
    bus.ls_size_i  = 3'b000;
    @(negedge clk);
    check("lsw_gnt",    bus.ls_gnt_o, 1'b1);
    check("lsw_htrans", bus.htrans_o, 2'b10);
    check("lsw_haddr",  bus.haddr_o,  32'h2000_0003);
    check("lsw_hsize",  bus.hsize_o,  3'b000);
    check("lsw_hwrite", bus.hwrite_o, 1'b1);
    bus.ls_req_i = 1'b0;
    @(negedge clk);
    check("lsw_data_htrans", bus.htrans_o, 2'b00);
    check("lsw_hwdata",      bus.hwdata_o, 32'h55);
    bus.hready_i = 1'b0;
    @(negedge clk);
    check("lsw_rvalid_c3", bus.ls_rvalid_o, 1'b0);
    @(negedge clk);
    check("lsw_rvalid_c4", bus.ls_rvalid_o, 1'b0);
    check("lsw_hwdata_c4", bus.hwdata_o,    32'h55);
    bus.hready_i = 1'b1;
    @(negedge clk);
    check("lsw_rvalid_c5", bus.ls_rvalid_o, 1'b1);
    check("lsw_err",       bus.ls_err_o,    1'b0);
    @(negedge clk);
  endtask

  task automatic test_contention();
    int order[$];
    int gcyc[$];
    int if_left = 4;
    int ls_left = 4;
    int got_o, exp_o;
    idle_inputs();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_1000;
    bus.ls_req_i  = 1'b1;
    bus.ls_addr_i = 32'h3000_0000;
    for (int c = 1; c <= 40 && (if_left + ls_left) > 0; c++) begin
      @(negedge clk);
      if (bus.ls_gnt_o) begin
        check("cont_ls_haddr", bus.haddr_o, bus.ls_addr_i);
        order.push_back(1);
        gcyc.push_back(c);
        ls_left--;
        if (ls_left == 0) bus.ls_req_i = 1'b0;
        else bus.ls_addr_i = bus.ls_addr_i + 32'd4;
      end
      if (bus.if_gnt_o) begin
        check("cont_if_haddr", bus.haddr_o, bus.if_addr_i);
        order.push_back(0);
        gcyc.push_back(c);
        if_left--;
        if (if_left == 0) bus.if_req_i = 1'b0;
        else bus.if_addr_i = bus.if_addr_i + 32'd4;
      end
    end
    check("cont_grants", order.size(), 8);
    for (int i = 0; i < 8; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_o = (i % 2 == 0) ? 1 : 0;
`else
      exp_o = (i < 4) ? 1 : 0;
`endif
      got_o = (i < order.size()) ? order[i] : 2;
      check($sformatf("cont_owner_%0d", i), got_o, exp_o);
      if (i > 0 && i < gcyc.size())
        check($sformatf("cont_spacing_%0d", i), gcyc[i] - gcyc[i-1], 2);
    end
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_flush();
    idle_inputs();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0200;
    @(negedge clk);
    check("fl_if_gnt", bus.if_gnt_o, 1'b1);
    bus.if_req_i = 1'b0;
    @(negedge clk);
    bus.hready_i   = 1'b0;
    bus.if_flush_i = 1'b1;
    @(negedge clk);
    bus.if_flush_i = 1'b0;
    bus.ls_req_i   = 1'b1;
    bus.ls_addr_i  = 32'h3000_0040;
    check("fl_wait_htrans", bus.htrans_o,    2'b00);
    check("fl_rvalid_c3",   bus.if_rvalid_o, 1'b0);
    @(negedge clk);
    bus.hready_i = 1'b1;
    check("fl_rvalid_c4", bus.if_rvalid_o, 1'b0);
    @(negedge clk);
    check("fl_rvalid_c5", bus.if_rvalid_o, 1'b0);
    check("fl_ls_gnt",    bus.ls_gnt_o,    1'b1);
    check("fl_ls_htrans", bus.htrans_o,    2'b10);
    check("fl_ls_haddr",  bus.haddr_o,     32'h3000_0040);
    bus.ls_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("fl_ls_rvalid",    bus.ls_rvalid_o, 1'b1);
    check("fl_if_rvalid_c7", bus.if_rvalid_o, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_error();
    idle_inputs();
    bus.ls_req_i  = 1'b1;
    bus.ls_addr_i = 32'h4000_0000;
    @(negedge clk);
    check("err_gnt", bus.ls_gnt_o, 1'b1);
    bus.ls_req_i = 1'b0;
    @(negedge clk);
    bus.hresp_i  = 1'b1;
    bus.hrdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    check("err_rvalid", bus.ls_rvalid_o, 1'b1);
    check("err_err",    bus.ls_err_o,    1'b1);
    check("err_rdata",  bus.ls_rdata_o,  32'h0);
    bus.hresp_i = 1'b0;
    @(negedge clk);
    check("err_err_pulse", bus.ls_err_o, 1'b0);
  endtask

  task automatic test_reset_mid_data();
    idle_inputs();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0300;
    bus.hrdata_i  = 32'h1234_5678;
    @(negedge clk);
    check("mr_gnt", bus.if_gnt_o, 1'b1);
    bus.if_req_i = 1'b0;
    @(negedge clk);
    bus.hready_i = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_values("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    bus.hready_i  = 1'b1;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0400;
    bus.hrdata_i  = 32'hCAFE_F00D;
    @(negedge clk);
    check("mr2_gnt",   bus.if_gnt_o, 1'b1);
    check("mr2_haddr", bus.haddr_o,  32'h400);
    bus.if_req_i = 1'b0;
    @(negedge clk);
    check("mr2_rvalid_c2", bus.if_rvalid_o, 1'b0);
    @(negedge clk);
    check("mr2_rvalid_c3", bus.if_rvalid_o, 1'b1);
    check("mr2_rdata",     bus.if_rdata_o,  32'hCAFE_F00D);
    @(negedge clk);
  endtask

  // Transaction-level model: which master owns the next address phase, what it carries,
  // and which response each completed data phase must produce one cycle later.
  task automatic run_random();
    xfer_t       if_x, ls_x, addr_x, dp_x;
    bit          if_pend = 0, ls_pend = 0, in_addr = 0, dp_active = 0, dp_drop = 0;
    bit          win_ls = 0, dp_ls = 0, last_ls = 0;
    bit          exp_if_rv = 0, exp_ls_rv = 0, exp_if_err = 0, exp_ls_err = 0;
    bit          rq_if, rq_ls, arb, hr, hp, fl;
    logic [31:0] exp_if_rd = '0, exp_ls_rd = '0, rd;
    if_x = '0; ls_x = '0; addr_x = '0; dp_x = '0;
    for (int k = 0; k < RND_CYCLES; k++) begin
      @(negedge clk);
      check("rnd_htrans", bus.htrans_o, in_addr ? 2'b10 : 2'b00);
      if (in_addr) begin
        check("rnd_haddr",  bus.haddr_o,  addr_x.addr);
        check("rnd_hwrite", bus.hwrite_o, addr_x.we);
        check("rnd_hsize",  bus.hsize_o,  addr_x.size);
      end
      if (dp_active && dp_x.we) check("rnd_hwdata", bus.hwdata_o, dp_x.wdata);
      check("rnd_if_rvalid", bus.if_rvalid_o, exp_if_rv);
      check("rnd_ls_rvalid", bus.ls_rvalid_o, exp_ls_rv);
      if (exp_if_rv) begin
        check("rnd_if_rdata", bus.if_rdata_o, exp_if_rd);
        check("rnd_if_err",   bus.if_err_o,   exp_if_err);
      end
      if (exp_ls_rv) begin
        check("rnd_ls_rdata", bus.ls_rdata_o, exp_ls_rd);
        check("rnd_ls_err",   bus.ls_err_o,   exp_ls_err);
      end

      hr = ($urandom_range(0, 3) != 0);
      hp = dp_active && ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 11) == 0);
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_x.addr  = $urandom & 32'hFFFF_FFFC;
        if_x.we    = 1'b0;
        if_x.size  = 3'b010;
        if_x.wdata = '0;
        if_pend    = 1;
      end
      if (!ls_pend && $urandom_range(0, 2) == 0) begin
        ls_x.addr  = $urandom;
        ls_x.we    = 1'($urandom_range(0, 1));
        ls_x.size  = 3'($urandom_range(0, 2));
        ls_x.wdata = $urandom;
        ls_pend    = 1;
      end
      bus.hready_i   = hr;
      bus.hresp_i    = hp;
      bus.hrdata_i   = dp_active ? slave_data(dp_x.addr) : $urandom;
      bus.if_flush_i = fl;
      bus.if_req_i   = if_pend;
      bus.if_addr_i  = if_x.addr;
      bus.ls_req_i   = ls_pend;
      bus.ls_we_i    = ls_x.we;
      bus.ls_addr_i  = ls_x.addr;
      bus.ls_size_i  = ls_x.size;
      bus.ls_wdata_i = ls_x.wdata;
      #1;
      check("rnd_if_gnt", bus.if_gnt_o, in_addr && hr && !win_ls);
      check("rnd_ls_gnt", bus.ls_gnt_o, in_addr && hr && win_ls);

      rq_if = if_pend;
      rq_ls = ls_pend;
      exp_if_rv = 0; exp_ls_rv = 0; exp_if_err = 0; exp_ls_err = 0;
      arb = (!in_addr && !dp_active) || (dp_active && hr);
      if (dp_active && !dp_ls && fl) dp_drop = 1;
      if (dp_active && hr) begin
        rd = hp ? 32'h0 : slave_data(dp_x.addr);
        if (dp_ls) begin
          exp_ls_rv = 1; exp_ls_rd = rd; exp_ls_err = hp;
        end else if (!dp_drop) begin
          exp_if_rv = 1; exp_if_rd = rd; exp_if_err = hp;
        end
        dp_active = 0;
      end
      if (in_addr && hr) begin
        dp_active = 1;
        dp_ls     = win_ls;
        dp_x      = addr_x;
        dp_drop   = 0;
        last_ls   = win_ls;
        if (win_ls) ls_pend = 0;
        else        if_pend = 0;
        in_addr   = 0;
      end
      if (arb && (rq_if || rq_ls)) begin
`ifdef ARB_ROUND_ROBIN_EN
        win_ls = (rq_if && rq_ls) ? !last_ls : rq_ls;
`else
        win_ls = rq_ls;
`endif
        addr_x  = win_ls ? ls_x : if_x;
        in_addr = 1;
      end
    end
  endtask

  initial begin
    do_reset();
    test_single_if();
    test_ls_write();
    test_contention();
    test_flush();
    test_error();
    test_reset_mid_data();
    do_reset();
    run_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed %0d checks", n_checks);
    $fatal(1, "time limit");
  end

endmodule
